mem_requester: RTL and testbench
================================

# mem_requester

Initiator-side controller for the stalling single-cycle memory interface (Rd/Wr/Addr/DataIn in; DataOut/Done/Stall/err out). It accepts one word-sized load or store from a pipeline stage through a valid/ready handshake and drives the memory request. It holds all request signals stable until the memory reports Done, then returns a one-cycle response with read data and error status. It sits between the fetch/memory stage and the instruction or data memory.

## Interface
- TIMEOUT, 64: consecutive stalled cycles in ACCESS before the access is aborted; legal range 1..65535.
- clk  in  1  single clock, all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  1  upstream request present.
- req_ready  out  1  block can accept a request.
- req_wr  in  1  1 = store, 0 = load.
- req_addr  in  16  byte address.
- req_wdata  in  32  store data.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_rdata  out  32  load data; 0 for stores and errors.
- rsp_err  out  1  misaligned address, memory err, or timeout.
- rsp_timeout  out  1  response was caused by a timeout abort.
- mem_Rd  out  1  memory read request.
- mem_Wr  out  1  memory write request.
- mem_Addr  out  16  memory address.
- mem_DataIn  out  32  memory write data.
- mem_DataOut  in  32  memory read data, valid when mem_Done.
- mem_Done  in  1  access completed this cycle.
- mem_Stall  in  1  access not taken this cycle.
- mem_err  in  1  memory-reported alignment error.
- stall_count  out  16  saturating total of stalled ACCESS cycles since reset.

## Operation
- States: IDLE, ACCESS, RESP. State and all outputs are registered, or decoded only from registered state.
- IDLE: req_ready=1. On req_valid, latch wr, addr, and wdata.
  - If addr[1:0]!=0, go to RESP with err=1. The memory is not accessed.
  - Otherwise go to ACCESS with stall counter = 0.
- ACCESS: mem_Rd=~wr and mem_Wr=wr, driven from latched registers. mem_Addr and mem_DataIn stay constant for the whole state. req_ready=0.
  - mem_Done=1: capture mem_DataOut (only when loading, else 0) and mem_err, go to RESP. The write commits at this edge.
  - mem_Stall=1: increment the per-access counter and stall_count (saturating at 16'hFFFF).
  - If the per-access counter reaches TIMEOUT, deassert the request and go to RESP with err=1 and timeout=1.
  - If mem_Done and the TIMEOUT condition occur on the same edge, mem_Done wins.
- RESP: rsp_valid=1 with rsp_rdata, rsp_err, and rsp_timeout from registers; req_ready=0. Next state is IDLE unconditionally.
- Outside RESP: rsp_valid=0, rsp_rdata=0, rsp_err=0, rsp_timeout=0.
- Outside ACCESS: mem_Rd=mem_Wr=0, and mem_Addr and mem_DataIn hold their last latched values.
- A load with mem_err=1 returns rsp_rdata=0 and rsp_err=1.

## Timing
- Reset (rst=0, asynchronous) sets:
  - state=IDLE;
  - all latched registers, stall_count, and the per-access counter = 0;
  - mem_Rd=mem_Wr=0, rsp_*=0, req_ready=1 once the state is IDLE.
- Reset asserted mid-ACCESS drops mem_Rd/mem_Wr immediately, with no clock needed. The in-flight request is discarded with no response.
- Latency from accept edge to rsp_valid:
  - aligned, no stall: 2 cycles (accept → ACCESS, Done → RESP);
  - plus N cycles for N stalled cycles;
  - misaligned: 1 cycle.
- Throughput: at most one request per 3 cycles. A new request is accepted only in IDLE, the cycle after RESP.
- req_* inputs are sampled only on the accept edge. Changes during ACCESS or RESP are ignored.

## Test plan
- Load, no stall: mem word @0x0010 = 32'hDEADBEEF, mem_Done=1, req addr 16'h0010.
  - mem_Rd high for exactly 1 cycle.
  - rsp_valid 2 cycles after accept with rsp_rdata=32'hDEADBEEF, rsp_err=0.
- Store with 3 stalls: req_wr=1, addr 16'h0020, wdata 32'h12345678, mem_Stall for 3 cycles, then Done.
  - mem_Wr, mem_Addr, and mem_DataIn stable for 4 cycles.
  - A readback returns 32'h12345678.
  - stall_count=3.
- Misaligned: addr 16'h0003.
  - No mem_Rd/mem_Wr.
  - rsp_valid 1 cycle after accept with rsp_err=1, rsp_timeout=0, rsp_rdata=0.
- Timeout: TIMEOUT=4, mem_Done held 0 and mem_Stall held 1.
  - mem_Rd high for 4 cycles, then low.
  - rsp_err=1 and rsp_timeout=1.
  - stall_count=4.
- Reset mid-access: assert rst=0 in the 2nd stalled cycle.
  - mem_Rd falls without a clock edge.
  - After release: no rsp_valid, req_ready=1, stall_count=0.
- Back-to-back: req_valid held high with 3 loads, each getting an immediate Done.
  - Accepts spaced exactly 3 cycles apart.
  - Responses in order with the correct data.

Source files
------------

// File: rtl/mem_requester.sv
// mem_requester: valid/ready load/store initiator for a stalling single-cycle memory
module mem_requester #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wr,
  input  logic [15:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        rsp_timeout,
  output logic        mem_Rd,
  output logic        mem_Wr,
  output logic [15:0] mem_Addr,
  output logic [31:0] mem_DataIn,
  input  logic [31:0] mem_DataOut,
  input  logic        mem_Done,
  input  logic        mem_Stall,
  input  logic        mem_err,
  output logic [15:0] stall_count
);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  state_t state, next_state;
  logic        wr_q;
  logic [15:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic        err_q;
  logic        tmo_q;
  logic [15:0] cnt;
  logic [15:0] cnt_inc;
  logic        accept;
  logic        misaligned;
  logic        in_access;
  logic        timeout;
  // request decode; a completing access never counts as a timeout
  always_comb begin
    accept     = state == IDLE && req_valid;
    misaligned = req_addr[1:0] != 2'b00;
    in_access  = state == ACCESS;
    cnt_inc    = cnt + 16'd1;
    timeout    = in_access && !mem_Done && mem_Stall && cnt_inc == 16'(TIMEOUT);
  end
  // state register; reset drops any in-flight access without a response
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else state <= next_state;
  end
  // next-state: misaligned requests skip the memory entirely
  always_comb begin
    next_state = IDLE;
    next_state = state == IDLE   ? (req_valid ? (misaligned ? RESP : ACCESS) : IDLE) :
                 state == ACCESS ? ((mem_Done || timeout) ? RESP : ACCESS) :
                 IDLE;
  end
  // request latch, per-access stall counter and response capture
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      tmo_q       <= 1'b0;
      cnt         <= '0;
      stall_count <= '0;
    end else begin
      if (accept) begin
        wr_q    <= req_wr;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        rdata_q <= '0;
        err_q   <= misaligned;
        tmo_q   <= 1'b0;
        cnt     <= '0;
      end
      if (in_access && mem_Stall) begin
        cnt         <= cnt_inc;
        stall_count <= stall_count == 16'hFFFF ? stall_count : stall_count + 16'd1;
      end
      if (in_access && mem_Done) begin
        rdata_q <= (wr_q || mem_err) ? '0 : mem_DataOut;
        err_q   <= mem_err;
        tmo_q   <= 1'b0;
      end else if (timeout) begin
        rdata_q <= '0;
        err_q   <= 1'b1;
        tmo_q   <= 1'b1;
      end
    end
  end
  // outputs decoded only from registered state
  always_comb begin
    req_ready   = state == IDLE;
    mem_Rd      = in_access && !wr_q;
    mem_Wr      = in_access && wr_q;
    mem_Addr    = addr_q;
    mem_DataIn  = wdata_q;
    rsp_valid   = state == RESP;
    rsp_rdata   = state == RESP ? rdata_q : '0;
    rsp_err     = state == RESP && err_q;
    rsp_timeout = state == RESP && tmo_q;
  end
endmodule

// File: tb/tb_mem_requester.sv
// tb_mem_requester: directed table, corner sequences and random traffic against a transaction-level model
module tb_mem_requester;
  localparam int TO = 4;
  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_wr;
  logic [15:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        rsp_timeout;
  logic        mem_Rd;
  logic        mem_Wr;
  logic [15:0] mem_Addr;
  logic [31:0] mem_DataIn;
  logic [31:0] mem_DataOut;
  logic        mem_Done;
  logic        mem_Stall;
  logic        mem_err;
  logic [15:0] stall_count;

  mem_requester #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .mem_Rd(mem_Rd), .mem_Wr(mem_Wr), .mem_Addr(mem_Addr), .mem_DataIn(mem_DataIn),
    .mem_DataOut(mem_DataOut), .mem_Done(mem_Done), .mem_Stall(mem_Stall), .mem_err(mem_err),
    .stall_count(stall_count)
  );

  typedef struct {
    logic        wr;
    logic [15:0] addr;
    logic [31:0] wdata;
    int          nstall;
    logic        merr;
    logic        dual;
    logic        keep;
    int          lat;
    int          act;
    logic        err;
    logic        tmo;
    logic [31:0] rdata;
    logic [15:0] sc;
  } vec_t;

  int passed = 0;
  int total = 0;
  int cyc = 0;
  int stall_total = 0;
  logic [31:0] mem [64];
  logic [31:0] ref_mem [64];
  vec_t tbl [9];
  vec_t v;
  int acc;
  int acc_b [3];
  logic [31:0] r;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  function automatic vec_t mk(logic wr, logic [15:0] addr, logic [31:0] wdata, int n, logic merr,
                              logic dual, int lat, int act, logic err, logic tmo,
                              logic [31:0] rdata, logic [15:0] sc);
    vec_t x;
    x.wr = wr; x.addr = addr; x.wdata = wdata; x.nstall = n; x.merr = merr; x.dual = dual;
    x.keep = 1'b0; x.lat = lat; x.act = act; x.err = err; x.tmo = tmo; x.rdata = rdata; x.sc = sc;
    return x;
  endfunction

  // transaction-level reference: outcome follows from alignment, stall length and memory error
  task automatic model(inout vec_t x);
    logic mis, to;
    int s;
    mis = x.addr[1:0] != 2'b00;
    to = !mis && x.nstall >= TO;
    x.act = mis ? 0 : to ? TO : x.nstall + 1;
    x.lat = mis ? 1 : x.act + 1;
    x.err = mis || to || x.merr;
    x.tmo = to;
    x.rdata = (mis || to || x.wr || x.merr) ? 32'h0 : ref_mem[x.addr[7:2]];
    s = mis ? 0 : to ? TO : x.nstall + int'(x.dual);
    stall_total = (stall_total + s > 65535) ? 65535 : stall_total + s;
    x.sc = 16'(stall_total);
    if (!mis && !to && x.wr && !x.merr) ref_mem[x.addr[7:2]] = x.wdata;
  endtask

  // issue one request, act as the memory, and compare the response against x
  task automatic run(input string tag, input vec_t x, output int acc_cyc);
    int c, act, stl;
    bit seen, stab, dirok, addrok;
    logic [15:0] a0;
    logic [31:0] d0;
    req_wr = x.wr; req_addr = x.addr; req_wdata = x.wdata; req_valid = 1'b1;
    if (!req_ready) step();
    chk({tag, " ready"}, req_ready, 1);
    acc_cyc = cyc;
    c = 0; act = 0; stl = 0; seen = 0; stab = 1; dirok = 1; addrok = 1; a0 = '0; d0 = '0;
    while (!seen && c < 100) begin
      step();
      c++;
      if (!x.keep) req_valid = 1'b0;
      req_wr = 1'($urandom); req_addr = 16'($urandom); req_wdata = $urandom;
      mem_Done = 1'b0; mem_Stall = 1'b0; mem_err = 1'b0; mem_DataOut = $urandom;
      if (mem_Rd || mem_Wr) begin
        if (act == 0) begin a0 = mem_Addr; d0 = mem_DataIn; end
        else if (mem_Addr !== a0 || mem_DataIn !== d0) stab = 0;
        if (mem_Rd !== !x.wr || mem_Wr !== x.wr) dirok = 0;
        if (mem_Addr !== x.addr) addrok = 0;
        act++;
        if (stl < x.nstall) begin
          mem_Stall = 1'b1;
          stl++;
        end else begin
          mem_Done = 1'b1;
          mem_Stall = x.dual;
          mem_err = x.merr;
          if (!x.wr) mem_DataOut = mem[x.addr[7:2]];
          if (x.wr && !x.merr) mem[x.addr[7:2]] = mem_DataIn;
        end
      end
      if (rsp_valid) seen = 1;
    end
    mem_Done = 1'b0; mem_Stall = 1'b0; mem_err = 1'b0;
    chk({tag, " rsp_seen"}, seen, 1);
    chk({tag, " latency"}, c, x.lat);
    chk({tag, " mem_cycles"}, act, x.act);
    chk({tag, " rsp_err"}, rsp_err, x.err);
    chk({tag, " rsp_timeout"}, rsp_timeout, x.tmo);
    chk({tag, " rsp_rdata"}, rsp_rdata, x.rdata);
    chk({tag, " req_stable"}, stab & dirok & addrok, 1);
    chk({tag, " mem_Addr"}, mem_Addr, x.addr);
    chk({tag, " stall_count"}, stall_count, x.sc);
  endtask

  initial begin
    rst = 1'b0; req_valid = 0; req_wr = 0; req_addr = '0; req_wdata = '0;
    mem_DataOut = '0; mem_Done = 0; mem_Stall = 0; mem_err = 0;
    for (int i = 0; i < 64; i++) begin
      mem[i] = $urandom;
      ref_mem[i] = mem[i];
    end
    mem[4] = 32'hDEADBEEF;
    ref_mem[4] = 32'hDEADBEEF;
    tbl[0] = mk(0, 16'h0010, 32'h0,        0, 0, 0, 2, 1, 0, 0, 32'hDEADBEEF, 16'd0);
    tbl[1] = mk(1, 16'h0020, 32'h12345678, 3, 0, 0, 5, 4, 0, 0, 32'h0,        16'd3);
    tbl[2] = mk(0, 16'h0020, 32'h0,        0, 0, 0, 2, 1, 0, 0, 32'h12345678, 16'd3);
    tbl[3] = mk(0, 16'h0003, 32'h0,        0, 0, 0, 1, 0, 1, 0, 32'h0,        16'd3);
    tbl[4] = mk(0, 16'h0030, 32'h0,        9, 0, 0, 5, 4, 1, 1, 32'h0,        16'd7);
    tbl[5] = mk(0, 16'h0010, 32'h0,        0, 1, 0, 2, 1, 1, 0, 32'h0,        16'd7);
    tbl[6] = mk(0, 16'h0010, 32'h0,        3, 0, 1, 5, 4, 0, 0, 32'hDEADBEEF, 16'd11);
    tbl[7] = mk(1, 16'h0022, 32'hCAFEF00D, 0, 0, 0, 1, 0, 1, 0, 32'h0,        16'd11);
    tbl[8] = mk(1, 16'h001C, 32'hA5A5A5A5, 0, 1, 0, 2, 1, 1, 0, 32'h0,        16'd11);
    repeat (3) @(posedge clk);
    #1;
    chk("reset req_ready", req_ready, 1);
    chk("reset rsp_valid", rsp_valid, 0);
    chk("reset mem_rd_wr", {mem_Rd, mem_Wr}, 0);
    chk("reset stall_count", stall_count, 0);
    chk("reset mem_Addr", mem_Addr, 0);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 9; i++) run($sformatf("vec%0d", i), tbl[i], acc);
    step();
    req_wr = 0; req_addr = 16'h0040; req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    mem_Stall = 1'b1;
    step();
    chk("rst_mid rd_before", mem_Rd, 1);
    #1 rst = 1'b0;
    #1 chk("rst_mid rd_async_drop", mem_Rd, 0);
    mem_Stall = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("rst_mid no_rsp", rsp_valid, 0);
    end
    chk("rst_mid req_ready", req_ready, 1);
    chk("rst_mid stall_count", stall_count, 0);
    stall_total = 0;
    for (int i = 0; i < 150; i++) begin
      r = $urandom;
      v.wr = 1'($urandom_range(0, 1));
      v.addr = {8'h00, 1'b1, r[6:2], ($urandom_range(0, 3) == 0) ? r[1:0] : 2'b00};
      v.wdata = $urandom;
      v.nstall = $urandom_range(0, 5);
      v.merr = $urandom_range(0, 7) == 0;
      v.dual = $urandom_range(0, 5) == 0;
      v.keep = 1'b0;
      model(v);
      run("rand", v, acc);
      repeat ($urandom_range(0, 2)) step();
    end
    for (int i = 0; i < 3; i++) begin
      v.wr = 1'b0;
      v.addr = 16'h0080 + 16'(4 * i);
      v.wdata = '0;
      v.nstall = 0;
      v.merr = 1'b0;
      v.dual = 1'b0;
      v.keep = 1'b1;
      model(v);
      run($sformatf("b2b%0d", i), v, acc_b[i]);
    end
    req_valid = 1'b0;
    chk("b2b spacing01", acc_b[1] - acc_b[0], 3);
    chk("b2b spacing12", acc_b[2] - acc_b[1], 3);
    step();
    step();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
